// File: rtl/mem_mon_pkg.sv
// -----------------------------------------------------------------------------
// mem_mon_pkg
//   Shared definitions for the memory run monitor: verdict reason encodings,
//   the run FSM state type and a helper that sizes the per-tag age counters.
// -----------------------------------------------------------------------------
package mem_mon_pkg;

   localparam int REASON_W = 3;

   typedef enum logic [REASON_W-1:0] {
      RSN_NONE    = 3'd0,
      RSN_EXIT    = 3'd1,
      RSN_TIMEOUT = 3'd2,
      RSN_DUP     = 3'd3,
      RSN_STRAY   = 3'd4,
      RSN_LAT     = 3'd5
   } reason_t;

   // IDLE is only occupied while reset is held and for the first edge after
   // release; the monitor starts counting on entry to RUN.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL
   } state_t;

   // Width needed to hold ages 0..lat_limit; one bit minimum so the age
   // storage stays legal when the watchdog is disabled (lat_limit = 0).
   function automatic int age_width(input int lat_limit);
      return (lat_limit > 0) ? $clog2(lat_limit + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_tag_scoreboard.sv
// -----------------------------------------------------------------------------
// mem_tag_scoreboard
//   Tracks outstanding read tags for one memory channel: one valid bit and
//   one saturating age counter per tag value. Flags duplicate reads, stray
//   responses and tags that have been outstanding for LAT_LIMIT cycles.
//
// Ports
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   en         in   update enable (monitor is in RUN); state frozen otherwise
//   req_rd     in   read request accepted this cycle
//   req_tag    in   tag of the read request
//   resp_valid in   response accepted this cycle
//   resp_tag   in   tag of the response
//   dup_err    out  read request for a tag that stays outstanding
//   stray_err  out  response for a tag that is not outstanding
//   lat_err    out  some outstanding tag reaches LAT_LIMIT at this edge
//   resp_ok    out  response matched an outstanding tag (completed read)
// -----------------------------------------------------------------------------
module mem_tag_scoreboard
   import mem_mon_pkg::*;
#(
   parameter int TAG_BITS  = 5,
   parameter int LAT_LIMIT = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                req_rd,
   input  logic [TAG_BITS-1:0] req_tag,
   input  logic                resp_valid,
   input  logic [TAG_BITS-1:0] resp_tag,
   output logic                dup_err,
   output logic                stray_err,
   output logic                lat_err,
   output logic                resp_ok
);

   localparam int DEPTH = 1 << TAG_BITS;
   localparam int AGE_W = age_width(LAT_LIMIT);
   localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(LAT_LIMIT);
   // The error is raised in the cycle whose edge carries the age to
   // LAT_LIMIT, so the verdict lands exactly LAT_LIMIT cycles after the request.
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((LAT_LIMIT > 0) ? LAT_LIMIT - 1 : 0);

   logic [DEPTH-1:0] valid_q;
   logic [AGE_W-1:0] age_q [DEPTH];
   logic             same_tag;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch cannot be inferred.
      resp_ok   = resp_valid &&  valid_q[resp_tag];
      stray_err = resp_valid && !valid_q[resp_tag];
      // A response retiring the same tag in this cycle frees it for the request.
      same_tag  = resp_ok && (resp_tag == req_tag);
      dup_err   = req_rd && valid_q[req_tag] && !same_tag;
      lat_err   = 1'b0;
      if (LAT_LIMIT != 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (age_q[i] == AGE_LAST)) lat_err = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the tag storage is reset because the valid bits define the
         // protocol check itself; a stale bit after reset is a false verdict.
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else if (en) begin
         // NOTE: non-blocking assignments so every entry updates from the
         // same pre-edge state regardless of loop order.
         for (int i = 0; i < DEPTH; i++) begin
            // Request wins over response: the response retires the old
            // entry and the request immediately re-arms it with a fresh age.
            if (req_rd && (req_tag == TAG_BITS'(i))) begin
               valid_q[i] <= 1'b1;
               age_q[i]   <= '0;
            end else if (resp_ok && (resp_tag == TAG_BITS'(i))) begin
               valid_q[i] <= 1'b0;
            end else if (valid_q[i] && (age_q[i] != AGE_SAT)) begin
               age_q[i]   <= age_q[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_test_monitor.sv
// -----------------------------------------------------------------------------
// mem_test_monitor
//   Run monitor for core bring-up. Watches NUM_CH memory req/resp channels
//   through per-channel tag scoreboards, decodes the tohost exit code,
//   enforces a global cycle budget and reports a sticky verdict plus
//   per-channel traffic counters.
//
// Ports
//   clk         in   clock
//   reset_n     in   asynchronous active-low reset
//   max_cycles  in   global cycle budget, 0 = unlimited
//   csr         in   tohost exit code (1 = pass, >1 = fail)
//   req_fire    in   per-channel request handshake
//   req_rw      in   per-channel request direction, 1 = write
//   req_tag     in   packed request tags, channel c at [c*TAG_BITS +: TAG_BITS]
//   resp_valid  in   per-channel response valid
//   resp_tag    in   packed response tags
//   done        out  verdict reached (sticky)
//   pass        out  verdict is pass
//   reason      out  fail reason (see mem_mon_pkg::reason_t)
//   fail_ch     out  channel of a protocol/latency fail, else 0
//   exit_code   out  csr captured with the verdict
//   cycle_cnt   out  cycles spent in RUN, verdict cycle included
//   rd_cnt      out  packed per-channel completed read counts
//   wr_cnt      out  packed per-channel write request counts
// -----------------------------------------------------------------------------
module mem_test_monitor
   import mem_mon_pkg::*;
#(
   parameter int NUM_CH    = 1,
   parameter int TAG_BITS  = 5,
   parameter int CNT_BITS  = 32,
   parameter int LAT_LIMIT = 1024
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [CNT_BITS-1:0]          max_cycles,
   input  logic [31:0]                  csr,
   input  logic [NUM_CH-1:0]            req_fire,
   input  logic [NUM_CH-1:0]            req_rw,
   input  logic [NUM_CH*TAG_BITS-1:0]   req_tag,
   input  logic [NUM_CH-1:0]            resp_valid,
   input  logic [NUM_CH*TAG_BITS-1:0]   resp_tag,
   output logic                         done,
   output logic                         pass,
   output logic [REASON_W-1:0]          reason,
   output logic [$clog2(NUM_CH):0]      fail_ch,
   output logic [31:0]                  exit_code,
   output logic [CNT_BITS-1:0]          cycle_cnt,
   output logic [NUM_CH*CNT_BITS-1:0]   rd_cnt,
   output logic [NUM_CH*CNT_BITS-1:0]   wr_cnt
);

   localparam int FCH_W = $clog2(NUM_CH) + 1;

   state_t              state_q, state_d;
   reason_t             reason_q, reason_d;
   logic [FCH_W-1:0]    fail_ch_q, fail_ch_d;
   logic [31:0]         exit_code_q;
   logic [CNT_BITS-1:0] cycle_q, cycle_inc;
   logic [CNT_BITS-1:0] rd_q [NUM_CH];
   logic [CNT_BITS-1:0] wr_q [NUM_CH];
   logic [NUM_CH-1:0]   dup_err, stray_err, lat_err, resp_ok;
   logic                run;

   assign run = (state_q == ST_RUN);

   // ---------------------------------------------------------------------
   // Per-channel scoreboards
   // ---------------------------------------------------------------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mem_tag_scoreboard #(
         .TAG_BITS  (TAG_BITS),
         .LAT_LIMIT (LAT_LIMIT)
      ) u_sb (
         .clk        (clk),
         .reset_n    (reset_n),
         .en         (run),
         .req_rd     (req_fire[c] & ~req_rw[c]),
         .req_tag    (req_tag[c*TAG_BITS +: TAG_BITS]),
         .resp_valid (resp_valid[c]),
         .resp_tag   (resp_tag[c*TAG_BITS +: TAG_BITS]),
         .dup_err    (dup_err[c]),
         .stray_err  (stray_err[c]),
         .lat_err    (lat_err[c]),
         .resp_ok    (resp_ok[c])
      );

      assign rd_cnt[c*CNT_BITS +: CNT_BITS] = rd_q[c];
      assign wr_cnt[c*CNT_BITS +: CNT_BITS] = wr_q[c];
   end

   // ---------------------------------------------------------------------
   // Fail priority and next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      reason_d  = RSN_NONE;
      fail_ch_d = '0;
      // The budget counts the cycle being evaluated, so a budget of N ends
      // the run with cycle_cnt == N.
      cycle_inc = cycle_q + 1'b1;

      // Checks are applied lowest priority first so each later one overrides.
      // Channel loops run high to low so the lowest index wins.
      if ((max_cycles != '0) && (cycle_inc == max_cycles)) reason_d = RSN_TIMEOUT;
      if (csr > 32'd1) reason_d = RSN_EXIT;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (stray_err[c]) begin
            reason_d  = RSN_STRAY;
            fail_ch_d = FCH_W'(c);
         end
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (dup_err[c]) begin
            reason_d  = RSN_DUP;
            fail_ch_d = FCH_W'(c);
         end
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (lat_err[c]) begin
            reason_d  = RSN_LAT;
            fail_ch_d = FCH_W'(c);
         end
      end

      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            if (reason_d != RSN_NONE) state_d = ST_FAIL;
            else if (csr == 32'd1)    state_d = ST_PASS;
         end
         default: state_d = state_q; // PASS and FAIL hold until reset
      endcase
   end

   // ---------------------------------------------------------------------
   // State, verdict capture and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         reason_q    <= RSN_NONE;
         fail_ch_q   <= '0;
         exit_code_q <= '0;
         cycle_q     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            rd_q[c] <= '0;
            wr_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (run) begin
            cycle_q <= cycle_inc;
            for (int c = 0; c < NUM_CH; c++) begin
               if (resp_ok[c])              rd_q[c] <= rd_q[c] + 1'b1;
               if (req_fire[c] && req_rw[c]) wr_q[c] <= wr_q[c] + 1'b1;
            end
            // On a pass reason_d is NONE and fail_ch_d is 0 by construction.
            if (state_d != ST_RUN) begin
               reason_q    <= reason_d;
               fail_ch_q   <= fail_ch_d;
               exit_code_q <= csr;
            end
         end
      end
   end

   assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass      = (state_q == ST_PASS);
   assign reason    = reason_q;
   assign fail_ch   = fail_ch_q;
   assign exit_code = exit_code_q;
   assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_mem_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_mem_test_monitor
//   Directed bench for mem_test_monitor with two channels and an 8-cycle
//   latency limit. Inputs change 1 time unit after a rising edge; outputs are
//   sampled at the same point, before the next edge.
// -----------------------------------------------------------------------------
module tb_mem_test_monitor;

   localparam int NUM_CH    = 2;
   localparam int TAG_BITS  = 5;
   localparam int CNT_BITS  = 32;
   localparam int LAT_LIMIT = 8;

   logic                       clk = 1'b0;
   logic                       reset_n = 1'b0;
   logic [CNT_BITS-1:0]        max_cycles;
   logic [31:0]                csr;
   logic [NUM_CH-1:0]          req_fire, req_rw, resp_valid;
   logic [NUM_CH*TAG_BITS-1:0] req_tag, resp_tag;
   logic                       done, pass;
   logic [2:0]                 reason;
   logic [1:0]                 fail_ch;
   logic [31:0]                exit_code;
   logic [CNT_BITS-1:0]        cycle_cnt;
   logic [NUM_CH*CNT_BITS-1:0] rd_cnt, wr_cnt;

   int checks   = 0;
   int failures = 0;

   mem_test_monitor #(
      .NUM_CH    (NUM_CH),
      .TAG_BITS  (TAG_BITS),
      .CNT_BITS  (CNT_BITS),
      .LAT_LIMIT (LAT_LIMIT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .max_cycles (max_cycles),
      .csr        (csr),
      .req_fire   (req_fire),
      .req_rw     (req_rw),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_tag   (resp_tag),
      .done       (done),
      .pass       (pass),
      .reason     (reason),
      .fail_ch    (fail_ch),
      .exit_code  (exit_code),
      .cycle_cnt  (cycle_cnt),
      .rd_cnt     (rd_cnt),
      .wr_cnt     (wr_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      max_cycles = '0;
      csr        = '0;
      req_fire   = '0;
      req_rw     = '0;
      req_tag    = '0;
      resp_valid = '0;
      resp_tag   = '0;
   endtask

   // Leaves the DUT in RUN with cycle_cnt == 0.
   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n = 1'b0;
      #2;
      checks++;
      if ({done, pass, reason, fail_ch} !== 7'd0) begin
         failures++;
         $display("FAIL reset_flags: got %b required 0", {done, pass, reason, fail_ch});
      end
      checks++;
      if ({exit_code, cycle_cnt, rd_cnt, wr_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_values: got exit=%0d cyc=%0d rd=%0h wr=%0h required all 0",
                  exit_code, cycle_cnt, rd_cnt, wr_cnt);
      end
      tick(2);
      reset_n = 1'b1;
      tick(1);
      checks++;
      if (cycle_cnt !== 32'd0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_edge: got cyc=%0d done=%0d required 0 0", cycle_cnt, done);
      end
      tick(1);
      checks++;
      if (cycle_cnt !== 32'd1) begin
         failures++;
         $display("FAIL reset_run_count: got %0d required 1", cycle_cnt);
      end
   endtask

   task automatic test_pass();
      do_reset();
      tick(10);
      checks++;
      if (cycle_cnt !== 32'd10 || done !== 1'b0) begin
         failures++;
         $display("FAIL pass_pre: got cyc=%0d done=%0d required 10 0", cycle_cnt, done);
      end
      csr = 32'd1;
      tick(1);
      checks++;
      if ({done, pass, reason} !== {1'b1, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL pass_verdict: got done=%0d pass=%0d reason=%0d required 1 1 0", done, pass, reason);
      end
      checks++;
      if (exit_code !== 32'd1 || cycle_cnt !== 32'd11) begin
         failures++;
         $display("FAIL pass_values: got exit=%0d cyc=%0d required 1 11", exit_code, cycle_cnt);
      end
      csr = 32'd0;
      tick(3);
      checks++;
      if (cycle_cnt !== 32'd11 || pass !== 1'b1) begin
         failures++;
         $display("FAIL pass_frozen: got cyc=%0d pass=%0d required 11 1", cycle_cnt, pass);
      end
   endtask

   task automatic test_exit_fail();
      do_reset();
      csr = 32'd7;
      tick(1);
      checks++;
      if ({done, pass, reason, fail_ch} !== {1'b1, 1'b0, 3'd1, 2'd0}) begin
         failures++;
         $display("FAIL exit_verdict: got done=%0d pass=%0d reason=%0d ch=%0d required 1 0 1 0",
                  done, pass, reason, fail_ch);
      end
      checks++;
      if (exit_code !== 32'd7) begin
         failures++;
         $display("FAIL exit_code: got %0d required 7", exit_code);
      end
      csr = 32'd1;
      tick(2);
      checks++;
      if ({pass, reason} !== {1'b0, 3'd1} || exit_code !== 32'd7) begin
         failures++;
         $display("FAIL exit_sticky: got pass=%0d reason=%0d exit=%0d required 0 1 7", pass, reason, exit_code);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      max_cycles = 32'd50;
      tick(49);
      checks++;
      if (done !== 1'b0 || cycle_cnt !== 32'd49) begin
         failures++;
         $display("FAIL timeout_early: got done=%0d cyc=%0d required 0 49", done, cycle_cnt);
      end
      tick(1);
      checks++;
      if ({done, pass, reason} !== {1'b1, 1'b0, 3'd2} || cycle_cnt !== 32'd50) begin
         failures++;
         $display("FAIL timeout_verdict: got done=%0d pass=%0d reason=%0d cyc=%0d required 1 0 2 50",
                  done, pass, reason, cycle_cnt);
      end
   endtask

   task automatic test_dup_tag();
      do_reset();
      req_fire = 2'b10;
      req_tag  = {5'd3, 5'd0};
      tick(1);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL dup_first_req: got done=%0d required 0", done);
      end
      tick(1);
      clear_inputs();
      checks++;
      if ({done, reason, fail_ch} !== {1'b1, 3'd3, 2'd1}) begin
         failures++;
         $display("FAIL dup_verdict: got done=%0d reason=%0d ch=%0d required 1 3 1", done, reason, fail_ch);
      end
   endtask

   task automatic test_stray_resp();
      do_reset();
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd9};
      tick(1);
      clear_inputs();
      checks++;
      if ({done, pass, reason, fail_ch} !== {1'b1, 1'b0, 3'd4, 2'd0}) begin
         failures++;
         $display("FAIL stray_verdict: got done=%0d pass=%0d reason=%0d ch=%0d required 1 0 4 0",
                  done, pass, reason, fail_ch);
      end
   endtask

   task automatic test_priority();
      // dup on ch1, stray on ch0 and a fail exit code all in one cycle
      do_reset();
      req_fire = 2'b10;
      req_tag  = {5'd3, 5'd0};
      tick(1);
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd9};
      csr        = 32'd7;
      tick(1);
      clear_inputs();
      checks++;
      if ({reason, fail_ch} !== {3'd3, 2'd1} || exit_code !== 32'd7) begin
         failures++;
         $display("FAIL prio_dup_over_stray: got reason=%0d ch=%0d exit=%0d required 3 1 7",
                  reason, fail_ch, exit_code);
      end
      // stray on both channels: lowest index wins
      do_reset();
      resp_valid = 2'b11;
      resp_tag   = {5'd10, 5'd9};
      tick(1);
      clear_inputs();
      checks++;
      if ({reason, fail_ch} !== {3'd4, 2'd0}) begin
         failures++;
         $display("FAIL prio_low_channel: got reason=%0d ch=%0d required 4 0", reason, fail_ch);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      req_fire = 2'b01;
      req_tag  = {5'd0, 5'd4};
      tick(1);
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd4};
      tick(1);
      clear_inputs();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_no_err: got done=%0d reason=%0d required 0 0", done, reason);
      end
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd4};
      tick(1);
      clear_inputs();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_still_outstanding: got done=%0d reason=%0d required 0 0", done, reason);
      end
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd4};
      tick(1);
      clear_inputs();
      checks++;
      if ({reason, fail_ch} !== {3'd4, 2'd0}) begin
         failures++;
         $display("FAIL same_cycle_retired: got reason=%0d ch=%0d required 4 0", reason, fail_ch);
      end
      checks++;
      if (rd_cnt[31:0] !== 32'd2) begin
         failures++;
         $display("FAIL same_cycle_rd_cnt: got %0d required 2", rd_cnt[31:0]);
      end
   endtask

   task automatic test_counters();
      do_reset();
      req_fire = 2'b11;
      req_rw   = 2'b11;
      req_tag  = {5'd1, 5'd1};
      tick(1);
      req_fire = 2'b10;
      req_rw   = 2'b10;
      tick(2);
      req_rw   = 2'b00;
      req_tag  = {5'd5, 5'd0};
      tick(1);
      req_fire   = 2'b00;
      resp_valid = 2'b10;
      resp_tag   = {5'd5, 5'd0};
      tick(1);
      clear_inputs();
      csr = 32'd1;
      tick(1);
      csr = 32'd0;
      checks++;
      if (pass !== 1'b1 || cycle_cnt !== 32'd6) begin
         failures++;
         $display("FAIL cnt_pass: got pass=%0d reason=%0d cyc=%0d required 1 0 6", pass, reason, cycle_cnt);
      end
      checks++;
      if (wr_cnt[31:0] !== 32'd1 || wr_cnt[63:32] !== 32'd3) begin
         failures++;
         $display("FAIL cnt_wr: got ch0=%0d ch1=%0d required 1 3", wr_cnt[31:0], wr_cnt[63:32]);
      end
      checks++;
      if (rd_cnt[31:0] !== 32'd0 || rd_cnt[63:32] !== 32'd1) begin
         failures++;
         $display("FAIL cnt_rd: got ch0=%0d ch1=%0d required 0 1", rd_cnt[31:0], rd_cnt[63:32]);
      end
   endtask

   task automatic test_latency();
      do_reset();
      req_fire = 2'b01;
      req_tag  = {5'd0, 5'd2};
      tick(1);
      clear_inputs();
      tick(7);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL lat_early: got done=%0d reason=%0d required 0 0", done, reason);
      end
      tick(1);
      checks++;
      if ({done, reason, fail_ch} !== {1'b1, 3'd5, 2'd0}) begin
         failures++;
         $display("FAIL lat_verdict: got done=%0d reason=%0d ch=%0d required 1 5 0", done, reason, fail_ch);
      end
      checks++;
      if (cycle_cnt !== 32'd9) begin
         failures++;
         $display("FAIL lat_cycles: got %0d required 9", cycle_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_fire = 2'b01;
      req_tag  = {5'd0, 5'd6};
      tick(1);
      clear_inputs();
      csr = 32'd7;
      tick(1);
      clear_inputs();
      checks++;
      if ({done, reason} !== {1'b1, 3'd1} || cycle_cnt !== 32'd2) begin
         failures++;
         $display("FAIL async_pre: got done=%0d reason=%0d cyc=%0d required 1 1 2", done, reason, cycle_cnt);
      end
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({done, pass, reason, fail_ch} !== 7'd0 || {exit_code, cycle_cnt} !== '0) begin
         failures++;
         $display("FAIL async_clear: got done=%0d reason=%0d exit=%0d cyc=%0d required all 0",
                  done, reason, exit_code, cycle_cnt);
      end
      tick(1);
      reset_n = 1'b1;
      tick(1);
      resp_valid = 2'b01;
      resp_tag   = {5'd0, 5'd6};
      tick(1);
      clear_inputs();
      checks++;
      if ({reason, fail_ch} !== {3'd4, 2'd0} || cycle_cnt !== 32'd1) begin
         failures++;
         $display("FAIL async_restart: got reason=%0d ch=%0d cyc=%0d required 4 0 1", reason, fail_ch, cycle_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_exit_fail();
      test_timeout();
      test_dup_tag();
      test_stray_resp();
      test_priority();
      test_same_cycle();
      test_counters();
      test_latency();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
